serial_pattern_tx: RTL and testbench

- Serial bit-pattern transmitter; the generating end of the team's serial sequence-detector interface.
- Captures a WIDTH-bit pattern and emits it MSB-first, one bit per clock, on a single-bit line.
- Repeats the pattern a programmable number of times, with an optional idle gap between repetitions.
- Used to drive detector inputs (e.g. the 1001 detector) in-system and in loopback test.

---
 rtl/seq_pkg.sv | 15 +
 rtl/pattern_shifter.sv | 38 +++
 rtl/serial_pattern_tx.sv | 153 +++++++++++++++
 tb/tb_serial_pattern_tx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence-detector interface: FSM state
// encoding, idle line level and the reference 1001 pattern.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic       IDLE_LEVEL = 1'b0;
    localparam logic [3:0] PAT_1001   = 4'b1001;

endpackage

// File: rtl/pattern_shifter.sv
// Loadable MSB-first rotating shift register with bit counter. o_bit/o_last
// describe the bit being emitted at the coming edge (load or advance).
module pattern_shifter #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_adv,
    input  logic [WIDTH-1:0] i_pattern,
    output logic             o_bit,
    output logic             o_last
);

    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] r_sh;
    logic [IDX_W-1:0] r_idx;

    // Rotating (not shifting) keeps the pattern intact for the next
    // repetition: after WIDTH emissions r_sh is back to the loaded value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh  <= '0;
            r_idx <= '0;
        end else if (i_load) begin
            r_sh  <= {i_pattern[WIDTH-2:0], i_pattern[WIDTH-1]};
            r_idx <= IDX_W'(WIDTH - 2);
        end else if (i_adv) begin
            r_sh  <= {r_sh[WIDTH-2:0], r_sh[WIDTH-1]};
            r_idx <= (r_idx == '0) ? IDX_W'(WIDTH - 1) : r_idx - IDX_W'(1);
        end
    end

    assign o_bit  = i_load ? i_pattern[WIDTH-1] : r_sh[WIDTH-1];
    assign o_last = !i_load && (r_idx == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: sends a captured pattern MSB-first, repeated
// reps times with an optional idle gap, all outputs registered.
module serial_pattern_tx
    import seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             O,
    output logic             valid,
    output logic             last_bit,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    state_t           r_state, w_next_state;
    logic [CNT_W-1:0] r_reps, w_next_reps;
    logic [GAP_W-1:0] r_gap_cfg, w_next_gap_cfg;
    logic [GAP_W-1:0] r_gap_cnt, w_next_gap_cnt;
    logic             r_o, r_valid, r_last, r_busy, r_done;
    logic             w_o, w_valid, w_last, w_busy, w_done;
    logic             w_load, w_adv, w_emit;
    logic             w_bit, w_bit_last;

    pattern_shifter #(.WIDTH(WIDTH)) u_shifter (
        .i_clk     (Clk),
        .i_rst_n   (reset),
        .i_load    (w_load),
        .i_adv     (w_adv),
        .i_pattern (pattern),
        .o_bit     (w_bit),
        .o_last    (w_bit_last)
    );

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_reps    <= '0;
            r_gap_cfg <= '0;
            r_gap_cnt <= '0;
            r_o       <= IDLE_LEVEL;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_reps    <= w_next_reps;
            r_gap_cfg <= w_next_gap_cfg;
            r_gap_cnt <= w_next_gap_cnt;
            r_o       <= w_o;
            r_valid   <= w_valid;
            r_last    <= w_last;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    // Outputs are computed for the cycle after the edge, so r_last marks the
    // cycle currently carrying bit 0 and decides what follows it.
    always_comb begin
        w_next_state   = r_state;
        w_next_reps    = r_reps;
        w_next_gap_cfg = r_gap_cfg;
        w_next_gap_cnt = r_gap_cnt;
        w_load         = 1'b0;
        w_adv          = 1'b0;
        w_emit         = 1'b0;
        w_done         = 1'b0;
        w_o            = IDLE_LEVEL;
        w_valid        = 1'b0;
        w_last         = 1'b0;

        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_load         = 1'b1;
                    w_next_reps    = reps;
                    w_next_gap_cfg = gap;
                    if (reps != '0) begin
                        w_next_state = SHIFT;
                        w_emit       = 1'b1;
                    end else begin
                        w_next_state = DONE;
                        w_done       = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (abort) begin
                    w_next_state = IDLE;
                end else if (r_last) begin
                    w_next_reps = r_reps - CNT_W'(1);
                    if (r_reps == CNT_W'(1)) begin
                        w_next_state = DONE;
                        w_done       = 1'b1;
                    end else if (r_gap_cfg == '0) begin
                        w_adv  = 1'b1;
                        w_emit = 1'b1;
                    end else begin
                        w_next_state   = GAP;
                        w_next_gap_cnt = r_gap_cfg - GAP_W'(1);
                    end
                end else begin
                    w_adv  = 1'b1;
                    w_emit = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    w_next_state = IDLE;
                end else if (r_gap_cnt == '0) begin
                    w_next_state = SHIFT;
                    w_adv        = 1'b1;
                    w_emit       = 1'b1;
                end else begin
                    w_next_gap_cnt = r_gap_cnt - GAP_W'(1);
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        if (w_emit) begin
            w_o     = w_bit;
            w_valid = 1'b1;
            w_last  = w_bit_last;
        end

        w_busy = (w_next_state != IDLE);
    end

    assign O         = r_o;
    assign valid     = r_valid;
    assign last_bit  = r_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: hand-written per-cycle expectations
// for O/valid/last_bit/busy/done, plus abort, max-count and async reset cases.
module tb_serial_pattern_tx;
    import seq_pkg::*;

    logic       Clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] pattern;
    logic [3:0] reps;
    logic [2:0] gap;
    logic       O;
    logic       valid;
    logic       last_bit;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Loopback 1001 detector model fed from valid bits.
    logic [3:0] det_sh;
    int         det_hits;

    // Inputs driven when a mid-run start is requested.
    logic [3:0] alt_pat;
    logic [3:0] alt_reps;
    logic [2:0] alt_gap;

    serial_pattern_tx #(.WIDTH(4), .CNT_W(4), .GAP_W(3)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .pattern   (pattern),
        .reps      (reps),
        .gap       (gap),
        .O         (O),
        .valid     (valid),
        .last_bit  (last_bit),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at #1 after an edge with the DUT idle; returns in cycle 1.
    task automatic launch(input logic [3:0] p, input logic [3:0] r,
                          input logic [2:0] g, input logic ab);
        pattern = p;
        reps    = r;
        gap     = g;
        start   = 1'b1;
        abort   = ab;
        @(posedge Clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Vectors read left to right: the MSB of the n-bit field is cycle 1.
    task automatic run_cycles(input string tag, input int n,
                              input logic [31:0] e_o, input logic [31:0] e_v,
                              input logic [31:0] e_l, input logic [31:0] e_b,
                              input logic [31:0] e_d,
                              input logic [31:0] m_start, input logic [31:0] m_abort);
        logic [4:0] exp_q[$];
        logic [4:0] e;
        for (int i = 1; i <= n; i++)
            exp_q.push_back({e_o[n-i], e_v[n-i], e_l[n-i], e_b[n-i], e_d[n-i]});
        for (int i = 1; i <= n; i++) begin
            e = exp_q.pop_front();
            check($sformatf("%s.O@%0d", tag, i),     32'(O),        32'(e[4]));
            check($sformatf("%s.valid@%0d", tag, i), 32'(valid),    32'(e[3]));
            check($sformatf("%s.last@%0d", tag, i),  32'(last_bit), 32'(e[2]));
            check($sformatf("%s.busy@%0d", tag, i),  32'(busy),     32'(e[1]));
            check($sformatf("%s.done@%0d", tag, i),  32'(done),     32'(e[0]));
            if (valid) begin
                det_sh = {det_sh[2:0], O};
                if (det_sh == PAT_1001) det_hits++;
            end
            start = m_start[n-i];
            abort = m_abort[n-i];
            if (m_start[n-i]) begin
                pattern = alt_pat;
                reps    = alt_reps;
                gap     = alt_gap;
            end
            @(posedge Clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int vcnt;
        int lcnt;
        int dcyc;

        reset    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        pattern  = '0;
        reps     = '0;
        gap      = '0;
        alt_pat  = 4'b0110;
        alt_reps = 4'd5;
        alt_gap  = 3'd3;
        det_sh   = '0;
        det_hits = 0;

        #12;
        check("rst.O",     32'(O),         32'd0);
        check("rst.valid", 32'(valid),     32'd0);
        check("rst.last",  32'(last_bit),  32'd0);
        check("rst.busy",  32'(busy),      32'd0);
        check("rst.done",  32'(done),      32'd0);
        check("rst.state", 32'(dbg_state), 32'(IDLE));
        @(negedge Clk);
        reset = 1'b1;
        @(posedge Clk);
        #1;

        // Single repetition.
        launch(PAT_1001, 4'd1, 3'd0, 1'b0);
        run_cycles("single", 6, 6'b100100, 6'b111100, 6'b000100, 6'b111110, 6'b000010, 0, 0);

        // Back-to-back repetitions with loopback detection.
        det_sh   = '0;
        det_hits = 0;
        launch(PAT_1001, 4'd3, 3'd0, 1'b0);
        run_cycles("b2b", 14, 14'b10011001100100, 14'b11111111111100,
                   14'b00010001000100, 14'b11111111111110, 14'b00000000000010, 0, 0);
        check("b2b.det_hits", 32'(det_hits), 32'd3);

        // Gapped repetitions.
        launch(PAT_1001, 4'd2, 3'd2, 1'b0);
        run_cycles("gap", 12, 12'b100100100100, 12'b111100111100,
                   12'b000100000100, 12'b111111111110, 12'b000000000010, 0, 0);

        // Zero repetitions.
        launch(PAT_1001, 4'd0, 3'd0, 1'b0);
        run_cycles("zero", 2, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 0, 0);

        // Abort and start together in IDLE: abort wins.
        launch(PAT_1001, 4'd2, 3'd0, 1'b1);
        run_cycles("abwin", 2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);

        // start and new inputs while busy are ignored.
        alt_pat  = 4'b0110;
        alt_reps = 4'd5;
        alt_gap  = 3'd3;
        launch(PAT_1001, 4'd2, 3'd0, 1'b0);
        run_cycles("busy_start", 10, 10'b1001100100, 10'b1111111100,
                   10'b0001000100, 10'b1111111110, 10'b0000000010,
                   10'b0111100000, 10'b0);

        // Abort in cycle 2, fresh start accepted in cycle 3.
        alt_pat  = 4'b0110;
        alt_reps = 4'd1;
        alt_gap  = 3'd0;
        launch(PAT_1001, 4'd3, 3'd0, 1'b0);
        run_cycles("abort", 9, 9'b100011000, 9'b110111100, 9'b000000100,
                   9'b110111110, 9'b000000010, 9'b001000000, 9'b010000000);

        // Maximum reps and gap: 60 bits, 14 gaps of 7, done at cycle 159.
        launch(PAT_1001, 4'hF, 3'h7, 1'b0);
        vcnt = 0;
        lcnt = 0;
        dcyc = 0;
        for (int i = 1; i <= 400 && dcyc == 0; i++) begin
            if (valid)    vcnt++;
            if (last_bit) lcnt++;
            if (done)     dcyc = i;
            @(posedge Clk);
            #1;
        end
        check("max.valid_cnt", 32'(vcnt), 32'd60);
        check("max.last_cnt",  32'(lcnt), 32'd15);
        check("max.done_cyc",  32'(dcyc), 32'd159);
        check("max.busy_after", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a SHIFT cycle.
        launch(PAT_1001, 4'd3, 3'd0, 1'b0);
        run_cycles("pre_rst", 3, 3'b100, 3'b111, 3'b000, 3'b111, 3'b000, 0, 0);
        check("pre_rst.O@4", 32'(O), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst.O",     32'(O),         32'd0);
        check("arst.valid", 32'(valid),     32'd0);
        check("arst.last",  32'(last_bit),  32'd0);
        check("arst.busy",  32'(busy),      32'd0);
        check("arst.done",  32'(done),      32'd0);
        check("arst.state", 32'(dbg_state), 32'(IDLE));
        #10;
        reset = 1'b1;
        @(posedge Clk);
        #1;
        launch(4'b0110, 4'd1, 3'd0, 1'b0);
        run_cycles("post_rst", 6, 6'b011000, 6'b111100, 6'b000100, 6'b111110, 6'b000010, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
